// File: rtl/folded_modality_fuser.sv
// Folded majority bundler: accumulates per-bit votes from NUM_MODALITIES folded HVs
// and emits one full-width majority HV per sample, with sequence checking and flush.
module folded_modality_fuser #(
  parameter int HV_DIMENSION    = 2000,
  parameter int NUM_FOLDS       = 4,
  parameter int FOLD_WIDTH      = HV_DIMENSION / NUM_FOLDS,
  parameter int NUM_MODALITIES  = 3,
  parameter int NUM_FOLDS_WIDTH = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1,
  parameter int MOD_WIDTH       = (NUM_MODALITIES > 1) ? $clog2(NUM_MODALITIES) : 1,
  parameter int CNT_WIDTH       = $clog2(NUM_MODALITIES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       hvin_valid,
  output logic                       hvin_ready,
  input  logic [FOLD_WIDTH-1:0]      hvin,
  input  logic [NUM_FOLDS_WIDTH-1:0] fold_counter,
  input  logic [MOD_WIDTH-1:0]       modality,
  output logic                       hvout_valid,
  input  logic                       hvout_ready,
  output logic [HV_DIMENSION-1:0]    hvout,
  output logic                       seq_err
);

  typedef enum logic {ST_ACCUM, ST_OUTPUT} state_t;

  localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
  localparam logic [MOD_WIDTH-1:0]       LAST_MOD  = MOD_WIDTH'(NUM_MODALITIES - 1);
  localparam logic [CNT_WIDTH:0]         M_EXT     = (CNT_WIDTH + 1)'(NUM_MODALITIES);

  state_t state, state_nxt;

  logic [HV_DIMENSION-1:0][CNT_WIDTH-1:0] count, count_nxt;
  logic [HV_DIMENSION-1:0]                tie, tie_nxt, fused;
  logic [NUM_FOLDS_WIDTH-1:0]             exp_fold;
  logic [MOD_WIDTH-1:0]                   exp_mod;

  logic accept, in_order, take, last_beat;

  assign accept    = hvin_valid & hvin_ready & ~flush;
  assign in_order  = (modality == exp_mod) && (fold_counter == exp_fold);
  assign take      = accept & in_order;
  assign last_beat = (exp_mod == LAST_MOD) && (exp_fold == LAST_FOLD);

  // Vote update and majority are evaluated on the post-beat counts so the last beat
  // can register the fused HV directly, giving single-cycle output latency.
  always_comb begin
    logic hit;
    logic [CNT_WIDTH:0] twice;
    hit       = 1'b0;
    twice     = '0;
    count_nxt = count;
    tie_nxt   = tie;
    fused     = '0;
    for (int f = 0; f < NUM_FOLDS; f++) begin
      hit = take && (fold_counter == NUM_FOLDS_WIDTH'(f));
      for (int i = 0; i < FOLD_WIDTH; i++) begin
        count_nxt[f*FOLD_WIDTH+i] = count[f*FOLD_WIDTH+i] + CNT_WIDTH'(hit && hvin[i]);
        if (hit && (exp_mod == '0)) begin
          tie_nxt[f*FOLD_WIDTH+i] = hvin[i];
        end
      end
    end
    for (int b = 0; b < HV_DIMENSION; b++) begin
      twice    = {count_nxt[b], 1'b0};
      fused[b] = (twice > M_EXT) || ((twice == M_EXT) && tie_nxt[b]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hvin_ready  = 1'b0;
    hvout_valid = 1'b0;
    case (state)
      ST_ACCUM: begin
        hvin_ready = 1'b1;
        if (take && last_beat) begin
          state_nxt = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        hvout_valid = 1'b1;
        if (hvout_ready) begin
          state_nxt = ST_ACCUM;
        end
      end
      default: state_nxt = ST_ACCUM;
    endcase
  end

  // Flush only acts while accumulating; a completed HV waiting for handshake is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      tie      <= '0;
      exp_fold <= '0;
      exp_mod  <= '0;
      hvout    <= '0;
      seq_err  <= 1'b0;
    end else begin
      seq_err <= accept & ~in_order;
      if ((state == ST_ACCUM && flush) || (state == ST_OUTPUT && hvout_ready)) begin
        count    <= '0;
        tie      <= '0;
        exp_fold <= '0;
        exp_mod  <= '0;
      end else if (take) begin
        count <= count_nxt;
        tie   <= tie_nxt;
        if (last_beat) begin
          hvout <= fused;
        end
        if (exp_fold == LAST_FOLD) begin
          exp_fold <= '0;
          exp_mod  <= (exp_mod == LAST_MOD) ? '0 : exp_mod + 1'b1;
        end else begin
          exp_fold <= exp_fold + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_folded_modality_fuser.sv
// Scoreboard bench: two fuser instances (3 and 2 modalities, 32-bit HV, 4 folds) driven
// with directed samples; a negedge monitor pops expected HVs on every output handshake.
module tb_folded_modality_fuser;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        fl3 = 0, v3 = 0, or3 = 1;
  logic        r3, ov3, se3;
  logic [7:0]  d3 = '0;
  logic [1:0]  f3 = '0, m3 = '0;
  logic [31:0] o3;

  logic        fl2 = 0, v2 = 0, or2 = 1;
  logic        r2, ov2, se2;
  logic [7:0]  d2 = '0;
  logic [1:0]  f2 = '0;
  logic [0:0]  m2 = '0;
  logic [31:0] o2;

  int total = 0;
  int bad   = 0;
  int gap_max = 0;
  logic [31:0] exp3[$];
  logic [31:0] exp2[$];

  always #5 clk = ~clk;

  folded_modality_fuser #(.HV_DIMENSION(32), .NUM_FOLDS(4), .NUM_MODALITIES(3)) dut3 (
    .clk(clk), .rst(rst), .flush(fl3), .hvin_valid(v3), .hvin_ready(r3), .hvin(d3),
    .fold_counter(f3), .modality(m3), .hvout_valid(ov3), .hvout_ready(or3), .hvout(o3),
    .seq_err(se3)
  );

  folded_modality_fuser #(.HV_DIMENSION(32), .NUM_FOLDS(4), .NUM_MODALITIES(2)) dut2 (
    .clk(clk), .rst(rst), .flush(fl2), .hvin_valid(v2), .hvin_ready(r2), .hvin(d2),
    .fold_counter(f2), .modality(m2), .hvout_valid(ov2), .hvout_ready(or2), .hvout(o2),
    .seq_err(se2)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fuse_model(input logic [2:0][31:0] hvs, input int m);
    logic [31:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      ones = 0;
      for (int k = 0; k < m; k++) ones += int'(hvs[k][b]);
      if (2 * ones > m)       r[b] = 1'b1;
      else if (2 * ones == m) r[b] = hvs[0][b];
    end
    return r;
  endfunction

  // Output handshake is sampled half a cycle before the edge that completes it.
  always @(negedge clk) begin
    if (ov3 && or3) begin
      if (exp3.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL hvout3_unexpected actual=%h required=none", o3);
      end else begin
        check_output("hvout3", o3, exp3.pop_front());
      end
    end
    if (ov2 && or2) begin
      if (exp2.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL hvout2_unexpected actual=%h required=none", o2);
      end else begin
        check_output("hvout2", o2, exp2.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input int which, input int mod, input int fold, input logic [7:0] data);
    int   waited;
    logic rdy;
    if (which == 3) begin
      m3 = 2'(mod); f3 = 2'(fold); d3 = data; v3 = 1'b1;
    end else begin
      m2 = 1'(mod); f2 = 2'(fold); d2 = data; v2 = 1'b1;
    end
    waited = 0;
    do begin
      @(negedge clk);
      rdy = (which == 3) ? r3 : r2;
      @(posedge clk);
      waited++;
    end while (!rdy && waited < 200);
    #1;
    v3 = 1'b0;
    v2 = 1'b0;
    if (!rdy) begin
      total++; bad++;
      $display("[TB] FAIL beat_timeout actual=not_ready required=accepted (dut m=%0d)", which);
    end
  endtask

  task automatic send_sample(input int which, input logic [2:0][31:0] hvs, input logic [31:0] exp);
    int n;
    if (which == 3) exp3.push_back(exp);
    else            exp2.push_back(exp);
    for (int m = 0; m < which; m++) begin
      for (int f = 0; f < 4; f++) begin
        n = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (n) @(posedge clk);
        if (n > 0) #1;
        apply_stimulus(which, m, f, hvs[m][f*8 +: 8]);
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp3.size() != 0 || exp2.size() != 0) && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (exp3.size() != 0 || exp2.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL drain_timeout actual=%0d/%0d pending required=0/0", exp3.size(), exp2.size());
      exp3.delete();
      exp2.delete();
    end
  endtask

  logic soak_done = 1'b0;

  initial begin
    logic [2:0][31:0] hvs;
    logic [31:0]      e;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_ready",  {31'd0, r3},  32'd1);
    check_output("rst_valid",  {31'd0, ov3}, 32'd0);
    check_output("rst_hvout",  o3,           32'd0);
    check_output("rst_seqerr", {31'd0, se3}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;

    // Two all-ones modalities outvote an all-zeros one; latency checked on last beat.
    exp3.push_back(32'hFFFF_FFFF);
    for (int m = 0; m < 3; m++) begin
      for (int f = 0; f < 4; f++) begin
        if (m == 2 && f == 3) check_output("valid_before_last", {31'd0, ov3}, 32'd0);
        apply_stimulus(3, m, f, (m == 2) ? 8'h00 : 8'hFF);
      end
    end
    check_output("valid_after_last", {31'd0, ov3}, 32'd1);
    wait_idle();

    // Every bit tied between two modalities: modality 0 breaks the tie.
    send_sample(2, {32'h0, 32'h5555_5555, 32'hAAAA_AAAA}, 32'hAAAA_AAAA);
    send_sample(2, {32'h0, 32'hFFFF_FFFF, 32'h7856_3412}, 32'h7856_3412);
    wait_idle();

    // Out-of-order beat (m1,f2) while (m1,f1) is expected.
    exp3.push_back(32'h1717_1717);
    for (int f = 0; f < 4; f++) apply_stimulus(3, 0, f, 8'h0F);
    apply_stimulus(3, 1, 0, 8'h33);
    apply_stimulus(3, 1, 2, 8'hFF);
    check_output("seq_err_pulse", {31'd0, se3}, 32'd1);
    @(posedge clk) #1;
    check_output("seq_err_clear", {31'd0, se3}, 32'd0);
    for (int f = 1; f < 4; f++) apply_stimulus(3, 1, f, 8'h33);
    for (int f = 0; f < 4; f++) apply_stimulus(3, 2, f, 8'h55);
    wait_idle();

    // Backpressure: output held for 20 cycles while a beat is offered.
    or3 = 1'b0;
    send_sample(3, {32'h0F0F_0F0F, 32'h3C3C_3C3C, 32'hC3C3_C3C3}, 32'h0F0F_0F0F);
    m3 = 2'd1; f3 = 2'd3; d3 = 8'hFF; v3 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_output("hold_valid",  {31'd0, ov3}, 32'd1);
      check_output("hold_hvout",  o3,           32'h0F0F_0F0F);
      check_output("hold_ready",  {31'd0, r3},  32'd0);
      check_output("hold_seqerr", {31'd0, se3}, 32'd0);
    end
    @(posedge clk) #1;
    v3 = 1'b0;
    or3 = 1'b1;
    @(posedge clk) #1;
    check_output("release_ready", {31'd0, r3},  32'd1);
    check_output("release_valid", {31'd0, ov3}, 32'd0);
    send_sample(3, {32'h0, 32'h9999_9999, 32'h9999_9999}, 32'h9999_9999);
    wait_idle();

    // Flush after 5 beats drops the partial sample; the offered beat is not taken.
    for (int f = 0; f < 4; f++) apply_stimulus(3, 0, f, 8'hFF);
    apply_stimulus(3, 1, 0, 8'hFF);
    m3 = 2'd1; f3 = 2'd1; d3 = 8'hFF; v3 = 1'b1; fl3 = 1'b1;
    @(posedge clk) #1;
    v3 = 1'b0; fl3 = 1'b0;
    check_output("flush_no_seqerr", {31'd0, se3}, 32'd0);
    send_sample(3, {32'hFFFF_FFFF, 32'h0, 32'h0}, 32'h0000_0000);
    wait_idle();

    // Flush during OUTPUT has no effect.
    or3 = 1'b0;
    send_sample(3, {32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 32'hFFFF_FFFF);
    fl3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fl3 = 1'b0;
    check_output("flush_out_valid", {31'd0, ov3}, 32'd1);
    check_output("flush_out_hvout", o3,           32'hFFFF_FFFF);
    or3 = 1'b1;
    wait_idle();

    // Async reset after 7 beats, then again while an output is pending.
    for (int f = 0; f < 4; f++) apply_stimulus(3, 0, f, 8'hFF);
    for (int f = 0; f < 3; f++) apply_stimulus(3, 1, f, 8'hFF);
    @(negedge clk) #2;
    rst = 1'b0;
    #1;
    check_output("areset_valid", {31'd0, ov3}, 32'd0);
    check_output("areset_ready", {31'd0, r3},  32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    or3 = 1'b0;
    send_sample(3, {32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 32'hFFFF_FFFF);
    @(negedge clk) #2;
    rst = 1'b0;
    exp3.delete();
    #1;
    check_output("areset_out_valid", {31'd0, ov3}, 32'd0);
    check_output("areset_out_ready", {31'd0, r3},  32'd1);
    check_output("areset_out_hvout", o3,           32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    or3 = 1'b1;
    send_sample(3, {32'h0, 32'h5A5A_5A5A, 32'h5A5A_5A5A}, 32'h5A5A_5A5A);
    wait_idle();

    // Soak with random input gaps and random output backpressure against the model.
    gap_max = 2;
    fork
      begin
        for (int s = 0; s < 10; s++) begin
          hvs = {$urandom, $urandom, $urandom};
          e = fuse_model(hvs, 3);
          send_sample(3, hvs, e);
          hvs = {32'h0, $urandom, $urandom};
          e = fuse_model(hvs, 2);
          send_sample(2, hvs, e);
        end
        soak_done = 1'b1;
      end
      begin
        while (!soak_done) begin
          @(posedge clk) #1;
          or3 = 1'($urandom_range(0, 1));
        end
      end
    join
    or3 = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
